// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults and shared types for the raster generator.
package vga_pkg;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  typedef logic [15:0] coord_t;
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } vga_ctl_t;
  localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: PIPE_DLY-stage shift of the DAC control bits, advancing once per pixel.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int PIPE_DLY = 1
)(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en_i,
  input  vga_ctl_t ctl_i,
  output vga_ctl_t ctl_o
);
  generate
    if (PIPE_DLY == 0) begin : g_byp
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, en_i};
      assign ctl_o = ctl_i;
    end else begin : g_pipe
      vga_ctl_t stage_q [PIPE_DLY];
      // Reset flushes in-flight sync pulses so none outlives the reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) stage_q[i] <= CTL_IDLE;
        end else if (en_i) begin
          stage_q[0] <= ctl_i;
          for (int i = 1; i < PIPE_DLY; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign ctl_o = stage_q[PIPE_DLY-1];
    end
  endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider, raster counters and sync/blank decode for the VGA DAC.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = vga_pkg::H_VIS,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_VIS    = vga_pkg::V_VIS,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int PIPE_DLY = 1
)(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] hCount,
  output logic [15:0] vCount,
  output logic        bright,
  output logic        pixelEn,
  output logic        frameStart,
  output logic        hSync,
  output logic        vSync,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK
);
  localparam coord_t H_LAST   = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VIS);
  localparam coord_t V_VIS_C  = coord_t'(V_VIS);
  localparam coord_t HS_LO    = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_HI    = coord_t'(H_VIS + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO    = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_HI    = coord_t'(V_VIS + V_FP + V_SYNC - 1);
  localparam coord_t DIV_LAST = coord_t'(CLK_DIV - 1);
  localparam coord_t DIV_HALF = coord_t'(CLK_DIV / 2);
  coord_t   div_q, div_d, h_q, h_d, v_q, v_d;
  logic     pe_q, bright_q, bright_d, h_wrap;
  vga_ctl_t ctl_raw, ctl_dly;
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 16'd1;
    h_wrap   = (h_q == H_LAST);
    h_d      = h_wrap ? '0 : h_q + 16'd1;
    v_d      = !h_wrap ? v_q : (v_q == V_LAST) ? '0 : v_q + 16'd1;
    bright_d = (h_d < H_VIS_C) && (v_d < V_VIS_C);
  end
  // pixelEn is registered from the next divider value so it reads 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pe_q     <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      bright_q <= 1'b0;
    end else begin
      div_q <= div_d;
      pe_q  <= (div_d == DIV_LAST);
      if (pe_q) begin
        h_q      <= h_d;
        v_q      <= v_d;
        bright_q <= bright_d;
      end
    end
  end
  always_comb begin
    ctl_raw.hs      = !((h_q >= HS_LO) && (h_q <= HS_HI));
    ctl_raw.vs      = !((v_q >= VS_LO) && (v_q <= VS_HI));
    ctl_raw.blank_n = bright_q;
  end
  vga_sync_delay #(.PIPE_DLY(PIPE_DLY)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pe_q),
    .ctl_i (ctl_raw),
    .ctl_o (ctl_dly)
  );
  assign hCount      = h_q;
  assign vCount      = v_q;
  assign bright      = bright_q;
  assign pixelEn     = pe_q;
  assign frameStart  = pe_q && (h_q == '0) && (v_q == '0);
  assign hSync       = ctl_dly.hs;
  assign vSync       = ctl_dly.vs;
  assign VGA_BLANK_N = ctl_dly.blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = (CLK_DIV == 1) ? 1'b1 : (div_q >= DIV_HALF);
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboarded directed checks on a full-size and a tiny-raster instance.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] hc_m, vc_m, hc_s, vc_s;
  logic br_m, pe_m, fs_m, hs_m, vs_m, bl_m, sn_m, ck_m;
  logic br_s, pe_s, fs_s, hs_s, vs_s, bl_s, sn_s, ck_s;
  vga_timing_gen u_m (
    .clk(clk), .rst_n(rst_n), .hCount(hc_m), .vCount(vc_m), .bright(br_m),
    .pixelEn(pe_m), .frameStart(fs_m), .hSync(hs_m), .vSync(vs_m),
    .VGA_BLANK_N(bl_m), .VGA_SYNC_N(sn_m), .VGA_CLK(ck_m)
  );
  vga_timing_gen #(
    .CLK_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DLY(0)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .hCount(hc_s), .vCount(vc_s), .bright(br_s),
    .pixelEn(pe_s), .frameStart(fs_s), .hSync(hs_s), .vSync(vs_s),
    .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sn_s), .VGA_CLK(ck_s)
  );
  typedef struct {
    int k;
    int h;
    int v;
    bit br;
    bit hs;
    bit vs;
    bit bl;
  } exp_t;
  exp_t q_m[$], q_s[$];
  exp_t e_m, e_s;
  int total = 0, bad = 0;
  function automatic void chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s tick=%0d got=%0d want=%0d", nm, k, act, exp);
    end
  endfunction
  function automatic void cmp(input string t, input exp_t e, input logic [15:0] h, input logic [15:0] v,
                              input logic br, input logic hs, input logic vs, input logic bl);
    chk({t, ".hCount"}, e.k, 32'(h), e.h);
    chk({t, ".vCount"}, e.k, 32'(v), e.v);
    chk({t, ".bright"}, e.k, 32'(br), 32'(e.br));
    chk({t, ".hSync"}, e.k, 32'(hs), 32'(e.hs));
    chk({t, ".vSync"}, e.k, 32'(vs), 32'(e.vs));
    chk({t, ".blank_n"}, e.k, 32'(bl), 32'(e.bl));
  endfunction
  function automatic exp_t mk(input int k, h, v, input bit br, hs, vs, bl);
    exp_t e;
    e.k = k; e.h = h; e.v = v; e.br = br; e.hs = hs; e.vs = vs; e.bl = bl;
    return e;
  endfunction
  int tk_m = 0, cn_m = 0, nfs_m = 0, t0_m = -1, t800_m = -1;
  bit pd_m = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      tk_m = 0;
      pd_m = 1'b0;
    end else begin
      if (pd_m) tk_m++;
      cn_m++;
      if (q_m.size() > 0 && q_m[0].k == tk_m) begin
        e_m = q_m.pop_front();
        cmp("m", e_m, hc_m, vc_m, br_m, hs_m, vs_m, bl_m);
        if (e_m.k == 0) t0_m = cn_m;
        if (e_m.k == 800) t800_m = cn_m;
      end
      if (fs_m) nfs_m++;
      pd_m = pe_m;
    end
  end
  int tk_s = 0, nfs_s = 0, npe0_s = 0;
  bit pd_s = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      tk_s = 0;
      pd_s = 1'b0;
    end else begin
      if (pd_s) tk_s++;
      if (q_s.size() > 0 && q_s[0].k == tk_s) begin
        e_s = q_s.pop_front();
        cmp("s", e_s, hc_s, vc_s, br_s, hs_s, vs_s, bl_s);
      end
      if (fs_s) nfs_s++;
      if (tk_s > 0 && !pe_s) npe0_s++;
      pd_s = pe_s;
    end
  end
  initial begin
    // Full-size raster, PIPE_DLY=1: sync/blank show the previous tick's decode.
    q_m.push_back(mk(0,   0,   0, 0, 1, 1, 0));
    q_m.push_back(mk(1,   1,   0, 1, 1, 1, 0));
    q_m.push_back(mk(2,   2,   0, 1, 1, 1, 1));
    q_m.push_back(mk(640, 640, 0, 0, 1, 1, 1));
    q_m.push_back(mk(641, 641, 0, 0, 1, 1, 0));
    q_m.push_back(mk(656, 656, 0, 0, 1, 1, 0));
    q_m.push_back(mk(657, 657, 0, 0, 0, 1, 0));
    q_m.push_back(mk(752, 752, 0, 0, 0, 1, 0));
    q_m.push_back(mk(753, 753, 0, 0, 1, 1, 0));
    q_m.push_back(mk(799, 799, 0, 0, 1, 1, 0));
    q_m.push_back(mk(800, 0,   1, 1, 1, 1, 0));
    q_m.push_back(mk(801, 1,   1, 1, 1, 1, 1));
    // Tiny raster 8x6, no delay: hs low h=5..6, vs low v=4, visible 4x3.
    q_s.push_back(mk(0,  0, 0, 0, 1, 1, 0));
    q_s.push_back(mk(1,  1, 0, 1, 1, 1, 1));
    q_s.push_back(mk(4,  4, 0, 0, 1, 1, 0));
    q_s.push_back(mk(5,  5, 0, 0, 0, 1, 0));
    q_s.push_back(mk(6,  6, 0, 0, 0, 1, 0));
    q_s.push_back(mk(7,  7, 0, 0, 1, 1, 0));
    q_s.push_back(mk(8,  0, 1, 1, 1, 1, 1));
    q_s.push_back(mk(24, 0, 3, 0, 1, 1, 0));
    q_s.push_back(mk(32, 0, 4, 0, 1, 0, 0));
    q_s.push_back(mk(39, 7, 4, 0, 1, 0, 0));
    q_s.push_back(mk(40, 0, 5, 0, 1, 1, 0));
    q_s.push_back(mk(47, 7, 5, 0, 1, 1, 0));
    q_s.push_back(mk(48, 0, 0, 1, 1, 1, 1));
    repeat (5) @(posedge clk);
    #2;
    chk("rst.hCount", 0, 32'(hc_m), 0);
    chk("rst.vCount", 0, 32'(vc_m), 0);
    chk("rst.hSync", 0, 32'(hs_m), 1);
    chk("rst.vSync", 0, 32'(vs_m), 1);
    chk("rst.bright", 0, 32'(br_m), 0);
    chk("rst.blank_n", 0, 32'(bl_m), 0);
    chk("rst.pixelEn", 0, 32'(pe_m), 0);
    chk("rst.frameStart", 0, 32'(fs_m), 0);
    chk("rst.VGA_CLK", 0, 32'(ck_m), 0);
    chk("rst.VGA_SYNC_N", 0, 32'(sn_m), 0);
    chk("rst.s_hSync", 0, 32'(hs_s), 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 200 && q_s.size() > 0; i++) @(posedge clk);
    chk("s.drain", tk_s, 32'(q_s.size()), 0);
    chk("s.frameStart_count", tk_s, 32'(nfs_s), 2);
    chk("s.pixelEn_low_count", tk_s, 32'(npe0_s), 0);
    chk("s.VGA_CLK", tk_s, 32'(ck_s), 1);
    chk("s.VGA_SYNC_N", tk_s, 32'(sn_s), 0);
    for (int i = 0; i < 5000 && q_m.size() > 0; i++) @(posedge clk);
    chk("m.drain", tk_m, 32'(q_m.size()), 0);
    chk("m.line_clks", tk_m, 32'(t800_m - t0_m), 1600);
    chk("m.frameStart_count", tk_m, 32'(nfs_m), 1);
    for (int i = 0; i < 3000 && tk_m < 1500; i++) @(posedge clk);
    #2;
    chk("mid.hCount_before", tk_m, 32'(hc_m), 700);
    chk("mid.vCount_before", tk_m, 32'(vc_m), 1);
    chk("mid.hSync_before", tk_m, 32'(hs_m), 0);
    chk("mid.pixelEn_before", tk_m, 32'(pe_m), 1);
    chk("mid.VGA_CLK_before", tk_m, 32'(ck_m), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.hCount", tk_m, 32'(hc_m), 0);
    chk("mid.vCount", tk_m, 32'(vc_m), 0);
    chk("mid.hSync", tk_m, 32'(hs_m), 1);
    chk("mid.bright", tk_m, 32'(br_m), 0);
    chk("mid.blank_n", tk_m, 32'(bl_m), 0);
    chk("mid.pixelEn", tk_m, 32'(pe_m), 0);
    q_m.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    q_m.push_back(mk(1, 1, 0, 1, 1, 1, 0));
    q_m.push_back(mk(2, 2, 0, 1, 1, 1, 1));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 100 && q_m.size() > 0; i++) @(posedge clk);
    chk("mid.drain", tk_m, 32'(q_m.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
